// File: rtl/vga_source_capture.sv
// -----------------------------------------------------------------------------
// vga_source_capture
//
// Source-clock-domain front end for the AD9888 pixel bus. Registers the raw
// pixel data and syncs, finds the sync leading edges, tracks the pixel and line
// position, crops the active window and produces the source_en / source_db
// stream. It also produces the scaler_reset level, which toggles once per frame.
//
// Optional feature macro: SOURCE_MEAS_EN
//   defined   : h_total / v_total report measured clocks per line and lines
//               per frame.
//   undefined : h_total / v_total are tied to 0.
//
// Parameters
//   HS_POL, VS_POL   active level of hsync / vsync
//   H_START, V_START first active pixel / line after the sync leading edge
//
// Ports
//   source_clk        AD9888 sample clock (only clock)
//   rst_n             asynchronous active-low reset
//   hsync, vsync      raw syncs
//   din[23:0]         raw RGB sample
//   inpix_x, inpix_y  active width / height (quasi-static)
//   source_en         source_db holds an active-window pixel this cycle
//   source_db[23:0]   cropped pixel data (holds outside the window)
//   scaler_reset      toggles at every frame start
//   locked            a vsync leading edge has been seen since reset
//   h_total, v_total  measured line length / frame height
// -----------------------------------------------------------------------------
module vga_source_capture #(
    parameter logic        HS_POL  = 1'b1,
    parameter logic        VS_POL  = 1'b1,
    parameter logic [10:0] H_START = 11'd0,
    parameter logic [10:0] V_START = 11'd0
) (
    input  logic        source_clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [23:0] din,
    input  logic [10:0] inpix_x,
    input  logic [10:0] inpix_y,
    output logic        source_en,
    output logic [23:0] source_db,
    output logic        scaler_reset,
    output logic        locked,
    output logic [11:0] h_total,
    output logic [11:0] v_total
);

    // Saturating 11-bit increment for the position counters.
    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        logic [10:0] r;
        if (v == 11'h7FF) begin
            r = v;
        end else begin
            r = v + 11'd1;
        end
        return r;
    endfunction

    // True when pos lies in [start, start+len); 12-bit math so the end never wraps.
    function automatic logic in_span(input logic [10:0] pos,
                                     input logic [10:0] start,
                                     input logic [10:0] len);
        logic [11:0] p;
        logic [11:0] lo;
        logic [11:0] hi;
        p  = {1'b0, pos};
        lo = {1'b0, start};
        hi = lo + {1'b0, len};
        return (p >= lo) && (p < hi);
    endfunction

    logic        hs_d1_r;
    logic        hs_d2_r;
    logic        vs_d1_r;
    logic        vs_d2_r;
    logic [23:0] din_d1_r;
    // Position of the sample that sat in din_d1 on the previous cycle.
    logic [10:0] h_cnt_r;
    logic [10:0] v_cnt_r;
    logic        locked_r;
    logic        vs_edge_d_r;
    logic        scaler_reset_r;
    logic        source_en_r;
    logic [23:0] source_db_r;

    logic        hs_edge_s;
    logic        vs_edge_s;
    // Position of the sample currently in din_d1.
    logic [10:0] h_cnt_s;
    logic [10:0] v_cnt_s;
    logic        locked_s;
    logic        win_s;

    // Input stage: one register on data, two on the syncs for edge detection.
    always_ff @(posedge source_clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d1_r  <= ~HS_POL;
            hs_d2_r  <= ~HS_POL;
            vs_d1_r  <= ~VS_POL;
            vs_d2_r  <= ~VS_POL;
            din_d1_r <= 24'd0;
        end else begin
            hs_d1_r  <= hsync;
            hs_d2_r  <= hs_d1_r;
            vs_d1_r  <= vsync;
            vs_d2_r  <= vs_d1_r;
            din_d1_r <= din;
        end
    end

    // Edge detect, position of the din_d1 sample and the active-window test.
    always_comb begin
        hs_edge_s = (hs_d1_r == HS_POL) && (hs_d2_r != HS_POL);
        vs_edge_s = (vs_d1_r == VS_POL) && (vs_d2_r != VS_POL);
        h_cnt_s   = h_cnt_r;
        v_cnt_s   = v_cnt_r;
        locked_s  = locked_r;
        win_s     = 1'b0;

        if (hs_edge_s) begin
            h_cnt_s = 11'd0;
        end else begin
            h_cnt_s = sat_inc11(h_cnt_r);
        end

        // A frame start also restarts the line count even when hsync coincides.
        if (vs_edge_s) begin
            v_cnt_s = 11'd0;
        end else if (hs_edge_s) begin
            v_cnt_s = sat_inc11(v_cnt_r);
        end else begin
            v_cnt_s = v_cnt_r;
        end

        // The first frame-start sample already counts as locked, so a window
        // starting at line 0 / pixel 0 is not lost on the very first frame.
        locked_s = locked_r | vs_edge_s;
        win_s    = locked_s
                   && in_span(h_cnt_s, H_START, inpix_x)
                   && in_span(v_cnt_s, V_START, inpix_y);
    end

    // Position counters and lock flag.
    always_ff @(posedge source_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r  <= 11'd0;
            v_cnt_r  <= 11'd0;
            locked_r <= 1'b0;
        end else begin
            h_cnt_r  <= h_cnt_s;
            v_cnt_r  <= v_cnt_s;
            locked_r <= locked_s;
        end
    end

    // Frame-start toggle, delayed one stage so it lands three clocks after the pin edge.
    always_ff @(posedge source_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_edge_d_r    <= 1'b0;
            scaler_reset_r <= 1'b0;
        end else begin
            vs_edge_d_r <= vs_edge_s;
            if (vs_edge_d_r) begin
                scaler_reset_r <= ~scaler_reset_r;
            end else begin
                scaler_reset_r <= scaler_reset_r;
            end
        end
    end

    // Output register: data only updates inside the window, otherwise holds.
    always_ff @(posedge source_clk or negedge rst_n) begin
        if (!rst_n) begin
            source_en_r <= 1'b0;
            source_db_r <= 24'd0;
        end else begin
            source_en_r <= win_s;
            if (win_s) begin
                source_db_r <= din_d1_r;
            end else begin
                source_db_r <= source_db_r;
            end
        end
    end

    assign source_en    = source_en_r;
    assign source_db    = source_db_r;
    assign scaler_reset = scaler_reset_r;
    assign locked       = locked_r;

`ifdef SOURCE_MEAS_EN
    // Saturating count+1 widened to 12 bits for the measurement registers.
    function automatic logic [11:0] sat_len12(input logic [10:0] v);
        logic [12:0] s;
        logic [11:0] r;
        s = {2'b00, v} + 13'd1;
        if (s[12]) begin
            r = 12'hFFF;
        end else begin
            r = s[11:0];
        end
        return r;
    endfunction

    logic [11:0] h_total_r;
    logic [11:0] v_total_r;

    // Line / frame length capture; h_cnt_r still holds the last pixel of the ending line.
    always_ff @(posedge source_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_total_r <= 12'd0;
            v_total_r <= 12'd0;
        end else begin
            if (hs_edge_s) begin
                h_total_r <= sat_len12(h_cnt_r);
            end else begin
                h_total_r <= h_total_r;
            end
            if (vs_edge_s) begin
                v_total_r <= sat_len12(v_cnt_r);
            end else begin
                v_total_r <= v_total_r;
            end
        end
    end

    assign h_total = h_total_r;
    assign v_total = v_total_r;
`else
    assign h_total = 12'd0;
    assign v_total = 12'd0;
`endif

endmodule

// File: tb/tb_vga_source_capture.sv
// -----------------------------------------------------------------------------
// Testbench for vga_source_capture (H_START=4, V_START=2, active-high syncs).
// A sample-level reference model follows the pin stream cycle by cycle and its
// predictions are compared with the outputs at the expected latency. A table of
// window sizes drives whole-frame checks; hand sequences cover pre-lock,
// reset mid-line and measurement; random sync streams exercise glitches and
// counter saturation.
// -----------------------------------------------------------------------------
module tb_vga_source_capture;

    localparam int LINE_LEN    = 20;
    localparam int FRAME_LINES = 10;
    localparam int HST         = 4;
    localparam int VST         = 2;
`ifdef SOURCE_MEAS_EN
    localparam bit MEAS = 1'b1;
`else
    localparam bit MEAS = 1'b0;
`endif

    logic        source_clk;
    logic        rst_n;
    logic        hsync;
    logic        vsync;
    logic [23:0] din;
    logic [10:0] inpix_x;
    logic [10:0] inpix_y;
    logic        source_en;
    logic [23:0] source_db;
    logic        scaler_reset;
    logic        locked;
    logic [11:0] h_total;
    logic [11:0] v_total;

    vga_source_capture #(
        .HS_POL (1'b1),
        .VS_POL (1'b1),
        .H_START(11'd4),
        .V_START(11'd2)
    ) dut (
        .source_clk  (source_clk),
        .rst_n       (rst_n),
        .hsync       (hsync),
        .vsync       (vsync),
        .din         (din),
        .inpix_x     (inpix_x),
        .inpix_y     (inpix_y),
        .source_en   (source_en),
        .source_db   (source_db),
        .scaler_reset(scaler_reset),
        .locked      (locked),
        .h_total     (h_total),
        .v_total     (v_total)
    );

    initial source_clk = 1'b0;
    always #5 source_clk = ~source_clk;

    typedef struct {
        logic        en;
        logic [23:0] db;
        logic        sr;
        logic        lk;
        logic [11:0] ht;
        logic [11:0] vt;
    } obs_t;

    typedef struct {
        int ix;
        int iy;
        int per_frame;
        int first_db;
    } vec_t;

    // pipe[0] = prediction for the newest sample, pipe[1] one older, pipe[2] two older
    obs_t pipe [3];
    int checks = 0;
    int errors = 0;

    // reference model state (position of the most recent sample)
    int          m_px, m_ln, m_ht, m_vt;
    bit          m_prev_hs, m_prev_vs, m_locked, m_sr;
    logic [23:0] m_db;

    int          en_cnt, sr_tog;
    logic        sr_prev;
    bit          got_first;
    logic [23:0] first_db;
    int          g_px, g_ln;
    vec_t        tbl [7];

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_px = 0; m_ln = 0; m_ht = 0; m_vt = 0;
        m_prev_hs = 1'b0; m_prev_vs = 1'b0; m_locked = 1'b0; m_sr = 1'b0;
        m_db = 24'd0;
        for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 24'd0, 1'b0, 1'b0, 12'd0, 12'd0};
    endtask

    // Apply one sample to the pins and predict what it must produce.
    task automatic drive(input bit hs, input bit vs, input logic [23:0] d);
        obs_t o;
        bit   hs_e;
        bit   vs_e;
        hsync = hs;
        vsync = vs;
        din   = d;
        hs_e  = hs && !m_prev_hs;
        vs_e  = vs && !m_prev_vs;
        if (hs_e) begin
            if (MEAS) m_ht = (m_px + 1 > 4095) ? 4095 : m_px + 1;
            m_px = 0;
        end else begin
            m_px = (m_px < 2047) ? m_px + 1 : 2047;
        end
        if (vs_e) begin
            if (MEAS) m_vt = (m_ln + 1 > 4095) ? 4095 : m_ln + 1;
            m_ln     = 0;
            m_locked = 1'b1;
            m_sr     = ~m_sr;
        end else if (hs_e) begin
            m_ln = (m_ln < 2047) ? m_ln + 1 : 2047;
        end
        o.en = m_locked
               && (m_px >= HST) && (m_px < HST + int'(inpix_x))
               && (m_ln >= VST) && (m_ln < VST + int'(inpix_y));
        if (o.en) m_db = d;
        o.db = m_db;
        o.sr = m_sr;
        o.lk = m_locked;
        o.ht = 12'(m_ht);
        o.vt = 12'(m_vt);
        m_prev_hs = hs;
        m_prev_vs = vs;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = o;
    endtask

    // Sample outputs on the falling edge and compare with the model (2-cycle
    // data/lock/measure latency, 3-cycle scaler_reset latency).
    task automatic observe();
        @(negedge source_clk);
        checks++;
        if (source_en !== pipe[1].en || source_db !== pipe[1].db || locked !== pipe[1].lk ||
            h_total !== pipe[1].ht || v_total !== pipe[1].vt || scaler_reset !== pipe[2].sr) begin
            errors++;
            $display("FAIL cycle_model t=%0t got en=%b db=%h sr=%b lk=%b ht=%0d vt=%0d, expected en=%b db=%h sr=%b lk=%b ht=%0d vt=%0d",
                     $time, source_en, source_db, scaler_reset, locked, h_total, v_total,
                     pipe[1].en, pipe[1].db, pipe[2].sr, pipe[1].lk, pipe[1].ht, pipe[1].vt);
        end
        if (source_en === 1'b1) begin
            en_cnt++;
            if (!got_first) begin
                got_first = 1'b1;
                first_db  = source_db;
            end
        end
        if (scaler_reset !== sr_prev) sr_tog++;
        sr_prev = scaler_reset;
    endtask

    // Drive the next sample of the fixed 20x10 test timing and advance.
    task automatic gen_drive();
        drive(g_px < 2, g_ln == 0, 24'(g_ln * 256 + g_px));
        g_px++;
        if (g_px == LINE_LEN) begin
            g_px = 0;
            g_ln = (g_ln + 1) % FRAME_LINES;
        end
    endtask

    task automatic gen_cycle();
        observe();
        gen_drive();
    endtask

    // Run the fixed timing until (ln, px) is the next sample to be driven.
    task automatic run_to(input int ln, input int px);
        int n;
        n = 0;
        while (!(g_ln == ln && g_px == px) && n < 1000) begin
            gen_cycle();
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL run_to_bound: got %0d cycles, expected fewer than 1000", n);
        end
    endtask

    task automatic release_reset();
        @(negedge source_clk);
        rst_n = 1'b1;
        model_reset();
        sr_prev = 1'b0;
    endtask

    task automatic rand_line(input int len, input int hs_w, input bit vs_on, input bit glitch);
        bit hs;
        for (int p = 0; p < len; p++) begin
            observe();
            hs = (p < hs_w);
            if (glitch && $urandom_range(0, 29) == 0) hs = ~hs;
            drive(hs, vs_on, 24'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0; din = 24'd0;
        inpix_x = 11'd8; inpix_y = 11'd3;
        en_cnt = 0; sr_tog = 0; sr_prev = 1'b0; got_first = 1'b0; first_db = 24'd0;
        g_px = 0; g_ln = 0;
        model_reset();

        tbl[0] = '{8, 3, 24, 32'h000204};
        tbl[1] = '{0, 3, 0, 0};
        tbl[2] = '{8, 0, 0, 0};
        tbl[3] = '{16, 8, 128, 32'h000204};
        tbl[4] = '{20, 10, 128, 32'h000204};
        tbl[5] = '{1, 1, 1, 32'h000204};
        tbl[6] = '{3, 5, 15, 32'h000204};

        // reset state
        repeat (3) @(negedge source_clk);
        check_val("rst_source_en", int'(source_en), 0);
        check_val("rst_source_db", int'(source_db), 0);
        check_val("rst_scaler_reset", int'(scaler_reset), 0);
        check_val("rst_locked", int'(locked), 0);
        check_val("rst_h_total", int'(h_total), 0);
        check_val("rst_v_total", int'(v_total), 0);

        // pre-lock: release mid-frame, nothing until the first vsync edge
        g_ln = 6; g_px = 0;
        release_reset();
        gen_drive();
        en_cnt = 0;
        run_to(0, 0);
        check_val("prelock_en_count", en_cnt, 0);
        check_val("prelock_locked", int'(locked), 0);
        repeat (4) gen_cycle();
        check_val("postlock_locked", int'(locked), 1);

        // window table: change size during vertical blanking, then 2 frames
        for (int i = 0; i < 7; i++) begin
            run_to(0, 5);
            inpix_x   = 11'(tbl[i].ix);
            inpix_y   = 11'(tbl[i].iy);
            en_cnt    = 0;
            sr_tog    = 0;
            got_first = 1'b0;
            repeat (2 * LINE_LEN * FRAME_LINES) gen_cycle();
            check_val($sformatf("tbl%0d_en_count", i), en_cnt, 2 * tbl[i].per_frame);
            check_val($sformatf("tbl%0d_sr_toggles", i), sr_tog, 2);
            if (tbl[i].per_frame > 0)
                check_val($sformatf("tbl%0d_first_db", i), int'(first_db), tbl[i].first_db);
        end

        // measurement after several complete frames
        check_val("meas_h_total", int'(h_total), MEAS ? 20 : 0);
        check_val("meas_v_total", int'(v_total), MEAS ? 10 : 0);

        // reset mid-line during active output
        run_to(0, 5);
        inpix_x = 11'd8; inpix_y = 11'd3;
        run_to(3, 11);
        @(posedge source_clk);
        #2;
        check_val("midline_en_before", int'(source_en), 1);
        rst_n = 1'b0;
        #1;
        check_val("midline_en_drop", int'(source_en), 0);
        check_val("midline_db", int'(source_db), 0);
        check_val("midline_sr", int'(scaler_reset), 0);
        check_val("midline_locked", int'(locked), 0);
        check_val("midline_h_total", int'(h_total), 0);
        check_val("midline_v_total", int'(v_total), 0);
        repeat (3) @(negedge source_clk);
        release_reset();
        gen_drive();
        en_cnt = 0;
        run_to(0, 0);
        check_val("midline_quiet_en", en_cnt, 0);
        check_val("midline_quiet_locked", int'(locked), 0);
        en_cnt = 0;
        repeat (LINE_LEN * FRAME_LINES) gen_cycle();
        check_val("midline_next_frame_en", en_cnt, 24);

        // random sync streams with glitches against the model
        for (int blk = 0; blk < 4; blk++) begin
            @(negedge source_clk);
            rst_n   = 1'b0;
            inpix_x = 11'($urandom_range(0, 12));
            inpix_y = 11'($urandom_range(0, 5));
            repeat (2) @(negedge source_clk);
            release_reset();
            drive(1'b0, 1'b0, 24'($urandom));
            for (int f = 0; f < 8; f++) begin
                int nl;
                int vsl;
                nl  = $urandom_range(3, 12);
                vsl = $urandom_range(1, 2);
                for (int l = 0; l < nl; l++)
                    rand_line($urandom_range(3, 40), $urandom_range(1, 3), l < vsl, 1'b1);
                if (blk == 0 && f == 3) rand_line(2100, 0, 1'b0, 1'b0);
            end
        end
        repeat (4) observe();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_source_capture.md
# vga_source_capture

Front end of the source clock domain: samples the raw AD9888 pixel bus and its hsync/vsync, crops the active window, and produces the `source_en` / `source_db` / `scaler_reset` signals consumed by the source-to-scaler CDC FIFO stage. Every frame start (vsync leading edge) toggles `scaler_reset`, so the downstream both-edge detector restarts the scaler once per frame. Optional timing measurement reports line length and frame height for mode detection.

## Interface
- `HS_POL`, 1: active level of `hsync` (1 = active high).
- `VS_POL`, 1: active level of `vsync`.
- `H_START`, 11'd0: pixel index of the first active pixel after the hsync leading edge.
- `V_START`, 11'd0: line index of the first active line after the vsync leading edge.
- `source_clk  input  1`: AD9888 sample clock; the only clock.
- `rst_n  input  1`: asynchronous, active-low reset.
- `hsync  input  1`: raw horizontal sync.
- `vsync  input  1`: raw vertical sync.
- `din  input  24`: raw RGB sample.
- `inpix_x  input  11`: active width in pixels; quasi-static.
- `inpix_y  input  11`: active height in lines; quasi-static.
- `source_en  output  1`: `source_db` is an active-window pixel.
- `source_db  output  24`: cropped pixel data.
- `scaler_reset  output  1`: level that toggles at each frame start.
- `locked  output  1`: at least one vsync leading edge has been seen since reset.
- `h_total  output  12`: measured clocks per line (macro-dependent).
- `v_total  output  12`: measured lines per frame (macro-dependent).

## Operation
- Input stage: `hsync`, `vsync` and `din` are registered once (`hs_d1`, `vs_d1`, `din_d1`), and syncs a second time (`hs_d2`, `vs_d2`).
- Leading edges:
  - `hs_edge` = `hs_d1`==HS_POL && `hs_d2`!=HS_POL.
  - `vs_edge` is defined the same way using VS_POL.
- `h_cnt` (11 bit):
  - Cleared to 0 in the cycle `hs_edge` is true; the sample in `din_d1` that cycle is pixel 0.
  - Otherwise increments and saturates at 2047.
- `v_cnt` (11 bit):
  - Cleared to 0 on `vs_edge`, which wins over a coincident `hs_edge`.
  - Otherwise increments on `hs_edge` and saturates at 2047.
- Window test (12-bit compare, so no overflow):
  - `h_cnt` in [H_START, H_START+inpix_x).
  - `v_cnt` in [V_START, V_START+inpix_y).
  - `locked`=1.
- Output register: `source_en` <= window test; `source_db` <= `din_d1` when the window test passes, else holds its previous value.
- `inpix_x`==0 or `inpix_y`==0: `source_en` never asserts.
- `scaler_reset` inverts on every `vs_edge`.
- `locked` sets on the first `vs_edge` and clears only on reset.
- A change of `inpix_x`/`inpix_y` takes effect from the next pixel; it is required to be changed only during vertical blanking.

## Timing
- Reset values: `source_en`=0, `source_db`=0, `scaler_reset`=0, `locked`=0, `h_total`=0, `v_total`=0; all counters 0.
- Latency from `din` sample to `source_db`/`source_en`: 2 `source_clk` cycles.
- Latency from `vsync` leading edge at the pin to the `scaler_reset` toggle: 3 cycles.
- `source_en` has no backpressure; downstream FIFO overflow is the consumer's concern.
- Sync glitches:
  - A 1-cycle sync pulse still produces one edge.
  - A sync held active produces no further edges.
- Reset mid-line or mid-frame: all outputs return to their reset values immediately. No output is produced until a new `vs_edge` sets `locked`; counting restarts from the next edges.

## Configuration
- `SOURCE_MEAS_EN` defined:
  - On each `hs_edge`, `h_total` <= `h_cnt`+1 (12 bit, saturating at 4095), latched before the clear.
  - On each `vs_edge`, `v_total` <= `v_cnt`+1 (saturating).
  - Both outputs hold their value between edges. The first measurement after reset is partial.
- Undefined: `h_total` and `v_total` are tied to 0 and no measurement logic exists.

## Test plan
- Test-wide setup: H_START=4, V_START=2, `inpix_x`=8, `inpix_y`=3. Line = 20 clocks with a 2-clock active-high hsync; frame = 10 lines with a 1-line vsync; `din` = line*256 + pixel.
- Basic frame: send 3 frames -> frame 1 onward gives exactly 24 `source_en` cycles per frame, 8 contiguous per line on lines 2–4. First data = 0x000204, arriving 2 cycles after its sample. `scaler_reset` toggles once per frame.
- Measurement: with `SOURCE_MEAS_EN`, `h_total`=20 and `v_total`=10 from the second frame on. Without the macro, both read 0 throughout.
- Pre-lock: release reset mid-frame -> `source_en`=0 and `locked`=0 until the first vsync edge, then normal.
- Degenerate size: `inpix_x`=0 -> zero `source_en` over 2 frames; `scaler_reset` still toggles.
- Reset mid-line: assert `rst_n`=0 during active pixel 5 -> `source_en` drops the same cycle, all outputs read their reset values, and after release no output occurs until the next vsync edge.
